// File: rtl/mod_exp_engine_pkg.sv
// Shared types and timing helpers for the modular-exponentiation engine.
// MOD_EXP_CONST_TIME_EN selects the key-independent schedule in mod_exp_latency.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQUARE,
    MULT,
    HOLD
  } state_e;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  function automatic int MUL_CYCLES(input int mod_w);
    return mod_w + 1;
  endfunction

  // One modular multiplication for the base reduction, one per square and one per executed multiply.
  function automatic int mod_exp_latency(input int mod_w, input int exp_w, input int pop);
    int m;
    m = 1 + exp_w + (CONST_TIME ? exp_w : pop);
    return 1 + m * MUL_CYCLES(mod_w);
  endfunction

endpackage

// File: rtl/mod_exp_engine_if.sv
// Operand/result handshake bundle between a requester (master) and the exponentiation engine (slave).
interface mod_exp_engine_if #(
  parameter int MSG_W = 12,
  parameter int MOD_W = 24,
  parameter int EXP_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] msg_in;
  logic [EXP_W-1:0] key;
  logic [MOD_W-1:0] n;
  logic             out_valid;
  logic             out_ready;
  logic [MOD_W-1:0] result;
  logic             err;

  modport master (
    output in_valid, msg_in, key, n, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, msg_in, key, n, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/mod_exp_engine_mod_mul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n in one load cycle plus MOD_W steps.
// Requires b < n so that 2P + b stays below 3n and two conditional subtracts suffice.
module mod_mul #(
  parameter int MOD_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [MOD_W-1:0] a_i,
  input  logic [MOD_W-1:0] b_i,
  input  logic [MOD_W-1:0] n_i,
  output logic             done_o,
  output logic [MOD_W-1:0] p_o
);
  localparam int CNT_W = $clog2(MOD_W + 1);

  logic [MOD_W-1:0] a_q, b_q, n_q, p_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [MOD_W+1:0] n_ext, step_sum, step_red1;
  logic [MOD_W-1:0] step_p;

  always_comb begin
    n_ext     = {2'b00, n_q};
    step_sum  = {1'b0, p_q, 1'b0} + (a_q[MOD_W-1] ? {2'b00, b_q} : '0);
    step_red1 = (step_sum >= n_ext) ? step_sum - n_ext : step_sum;
    step_p    = MOD_W'((step_red1 >= n_ext) ? step_red1 - n_ext : step_red1);
  end

  // done fires during the final step so the caller can capture p_o on that same edge.
  assign done_o = busy_q && (cnt_q == CNT_W'(1));
  assign p_o    = step_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      n_q    <= n_i;
      p_q    <= '0;
      cnt_q  <= CNT_W'(MOD_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      p_q   <= step_p;
      a_q   <= a_q << 1;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply exponentiation over one shared mod_mul.
// Define MOD_EXP_CONST_TIME_EN to always run the multiply step and discard it for zero key bits.
module mod_exp_engine #(
  parameter int MSG_W = 12,
  parameter int MOD_W = 24,
  parameter int EXP_W = 24
) (
  input logic            clk,
  input logic            rst,
  mod_exp_engine_if.slave bus
);
  import mod_exp_pkg::*;

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_e           state_q, state_d;
  logic [MOD_W-1:0] msg_q, msg_d, n_q, n_d, base_q, base_d, acc_q, acc_d;
  logic [EXP_W-1:0] key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MOD_W-1:0] result_q, result_d;
  logic             err_q, err_d, start_q, start_d;
  logic [MOD_W-1:0] mul_a, mul_b, mul_p;
  logic             mul_done, advance;
  logic [MSG_W-1:0] msg_in_w;

  assign msg_in_w = bus.msg_in;

  mod_mul #(.MOD_W(MOD_W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_q),
    .a_i    (mul_a),
    .b_i    (mul_b),
    .n_i    (n_q),
    .done_o (mul_done),
    .p_o    (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    key_d    = key_q;
    n_d      = n_q;
    base_d   = base_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    err_d    = err_q;
    start_d  = 1'b0;
    advance  = 1'b0;
    mul_a    = acc_q;
    mul_b    = acc_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        msg_d = MOD_W'(msg_in_w);
        key_d = bus.key;
        n_d   = bus.n;
        if (bus.n < MOD_W'(2)) begin
          state_d  = HOLD;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          state_d = REDUCE;
          err_d   = 1'b0;
          start_d = 1'b1;
        end
      end
      REDUCE: begin
        mul_a = msg_q;
        mul_b = MOD_W'(1);
        if (mul_done) begin
          base_d  = mul_p;
          acc_d   = MOD_W'(1);
          idx_d   = IDX_W'(EXP_W - 1);
          state_d = SQUARE;
          start_d = 1'b1;
        end
      end
      SQUARE: if (mul_done) begin
        acc_d = mul_p;
`ifdef MOD_EXP_CONST_TIME_EN
        state_d = MULT;
        start_d = 1'b1;
`else
        if (key_q[idx_q]) begin
          state_d = MULT;
          start_d = 1'b1;
        end else begin
          advance = 1'b1;
        end
`endif
      end
      MULT: begin
        mul_b = base_q;
        if (mul_done) begin
          if (key_q[idx_q]) acc_d = mul_p;
          advance = 1'b1;
        end
      end
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Step to the next key bit, or publish the accumulator after bit 0.
    if (advance) begin
      if (idx_q == '0) begin
        state_d  = HOLD;
        result_d = acc_d;
      end else begin
        idx_d   = idx_q - IDX_W'(1);
        state_d = SQUARE;
        start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      msg_q    <= '0;
      key_q    <= '0;
      n_q      <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
      n_q      <= n_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      err_q    <= err_d;
      start_q  <= start_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.result    = result_q;
  assign bus.err       = err_q;
endmodule

// File: doc/mod_exp_engine.md
# mod_exp_engine

Parametrised modular-exponentiation engine computing `result = msg_in^key mod n` by left-to-right square-and-multiply over a bit-serial interleaved modular multiplier. It is the next-generation exponentiation core of the public-key decryption datapath. It generalises the fixed 12/24-bit engine to configurable operand widths, adds ready/valid handshakes on both sides, adds an error flag for illegal moduli, and provides an optional constant-time mode.

## Interface
- `MSG_W`, 12, message width; must be ≤ `MOD_W`.
- `MOD_W`, 24, modulus and result width.
- `EXP_W`, 24, exponent width.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands are valid.
- `in_ready`  out  1  engine can accept operands.
- `msg_in`  in  MSG_W  base, zero-extended to `MOD_W`.
- `key`  in  EXP_W  exponent.
- `n`  in  MOD_W  modulus.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  MOD_W  `msg_in^key mod n`.
- `err`  out  1  qualifies `result`; high when `n < 2`.

## Operation
- States: `IDLE`, `REDUCE`, `SQUARE`, `MULT`, `HOLD`.
- `IDLE`:
  - `in_ready` is 1.
  - On an accept (`in_valid && in_ready`), `msg_in`, `key` and `n` are registered.
  - If `n < 2`, go to `HOLD` with `result` = 0 and `err` = 1.
  - Otherwise go to `REDUCE`.
- `REDUCE`: `base = mod_mul(msg_in, 1)`, which reduces the base into [0, n). The accumulator is set to 1 and the bit index to `EXP_W-1`.
- `SQUARE`: `acc = mod_mul(acc, acc)`, then go to `MULT`.
- `MULT`:
  - If `key[i]` is set: `acc = mod_mul(acc, base)`.
  - If `key[i]` is clear, the behaviour depends on configuration (see below).
  - Then decrement `i`. If `i` wraps below 0, go to `HOLD`; otherwise go to `SQUARE`.
- `HOLD`:
  - `out_valid` is 1, and `result` and `err` are stable.
  - The state leaves to `IDLE` on the edge where `out_ready` is 1.
  - `in_ready` is 0 throughout.
- `mod_mul(a, b)` uses interleaved shift-add, scanning `a` MSB-first:
  - Each step computes `P = 2P + a_j·b`, then subtracts `n` up to twice. The compare/subtract is combinational, all within one cycle.
  - Precondition `b < n`; then `2P + b < 3n`.
  - The intermediate is `MOD_W+2` bits wide.
- `key = 0` with `n ≥ 2` gives `result = 1`. The full schedule still runs.
- Operands are sampled only on accept. Input changes while busy have no effect.

## Timing
- Reset values: state `IDLE`, `in_ready` = 1, `out_valid` = 0, `result` = 0, `err` = 0, all internal registers 0.
- Reset asserted mid-operation aborts immediately. No output is produced and no stale `out_valid` appears after release.
- Each `mod_mul` occupies exactly `MOD_W+1` cycles: a 1-cycle load plus `MOD_W` steps.
- With `M` = number of `mod_mul` calls, `out_valid` rises `L = 1 + M·(MOD_W+1)` cycles after the accept edge.
- When `n < 2`, `out_valid` rises 1 cycle after the accept edge.
- Back-to-back operation: the earliest next accept is the cycle after the `HOLD`→`IDLE` edge.

## Configuration
- `MOD_EXP_CONST_TIME_EN` defined:
  - `MULT` always executes `mod_mul(acc, base)`; the product is discarded when `key[i] = 0`.
  - `M = 1 + 2·EXP_W`, so latency is independent of `key`.
- Undefined:
  - `MULT` is skipped when `key[i] = 0`.
  - `M = 1 + EXP_W + popcount(key)`.

## Structure
- Package `mod_exp_pkg` holds:
  - the state enum;
  - a `MUL_CYCLES(MOD_W)` constant function;
  - a latency function of `(MOD_W, EXP_W, popcount)`, for the bench.
- Sub-module `mod_mul`:
  - Parameter `MOD_W`.
  - Ports: start/done pulse, operands `a` and `b`, modulus `n`, output `p`.
  - Instantiated once, shared across `REDUCE`, `SQUARE` and `MULT`.

## Test plan
- Default params, `msg_in`=9, `key`=7, `n`=143 → `result` 48, `err` 0, latency as follows:
  - with `MOD_EXP_CONST_TIME_EN`: 1226 cycles (M=49);
  - without it: 701 cycles (M=28).
- `msg_in`=48, `key`=103, `n`=143 → `result` 9 (RSA round-trip); `msg_in`=152 (≥ n), `key`=7, `n`=143 → `result` 48.
- `key`=0, `n`=143, `msg_in`=5 → `result` 1. `n`=1 or `n`=0 → `err` 1, `result` 0, `out_valid` 1 cycle after accept.
- Hold `out_ready` low for 20 cycles in `HOLD` → `result` and `out_valid` stable, `in_ready` 0. A second `in_valid` is not accepted until 1 cycle after `out_ready`.
- Assert `rst` mid-`SQUARE` → outputs return to their reset values immediately. A new request after release gives the correct result.
- Random params `MOD_W`=32, `EXP_W`=16, `MSG_W`=32, with 200 random vectors, `n ≥ 2` → `result` matches the reference model and latency matches the package function.
